fb_scan_reader: RTL and testbench

- PLB master-read engine: scans the framebuffer in raster order, one single-beat IPIF read per pixel.
- Each pixel is tagged with its line/col and pushed into a 64-bit FIFO for downstream consumers (display/compositing, readback of rasterizer output).
- Read-side counterpart of the framebuffer write path; uses the same address map and IPIF master signalling.

---
 rtl/fb_scan_reader.sv | 181 ++++++++++++++++++
 tb/tb_fb_scan_reader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scan_reader.sv
// rtl/fb_scan_reader.sv - raster-order framebuffer read engine feeding a tagged pixel FIFO
module fb_scan_reader #(
    parameter int          C_MST_AWIDTH = 32,
    parameter int          C_MST_DWIDTH = 32,
    parameter int          LINE_LEN     = 9,
    parameter int          COL_LEN      = 10,
    parameter int          NUM_LINES    = 480,
    parameter int          NUM_COLS     = 640,
    parameter logic [10:0] FB_BASE_HI   = 11'b1001_0000_000,
    parameter int          FBR_FIFO_LEN = 64
) (
    input  logic                        Bus2IP_Clk,
    input  logic                        Bus2IP_Resetn,
    input  logic                        start,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        err_sticky,
    output logic [FBR_FIFO_LEN-1:0]     fifo_Dout,
    output logic                        fifo_wr_en,
    input  logic                        fifo_full,
    output logic                        IP2Bus_MstRd_Req,
    output logic                        IP2Bus_MstWr_Req,
    output logic [C_MST_AWIDTH-1:0]     IP2Bus_Mst_Addr,
    output logic [C_MST_DWIDTH/8-1:0]   IP2Bus_Mst_BE,
    output logic                        IP2Bus_Mst_Lock,
    output logic                        IP2Bus_Mst_Reset,
    output logic                        IP2Bus_MstRd_dst_rdy_n,
    input  logic                        Bus2IP_Mst_CmdAck,
    input  logic                        Bus2IP_Mst_Cmplt,
    input  logic                        Bus2IP_Mst_Error,
    input  logic                        Bus2IP_Mst_Rearbitrate,
    input  logic                        Bus2IP_Mst_Cmd_Timeout,
    input  logic [C_MST_DWIDTH-1:0]     Bus2IP_MstRd_d,
    input  logic                        Bus2IP_MstRd_src_rdy_n
);

    // Raw address is {base, line, col, byte offset}; it is resized to the bus width.
    localparam int RAW_AW = 11 + LINE_LEN + COL_LEN + 2;
    // Zero gap between the col tag and the pixel in the FIFO word.
    localparam int PAD_W  = FBR_FIFO_LEN - LINE_LEN - COL_LEN - C_MST_DWIDTH;

    localparam logic [LINE_LEN-1:0] LAST_LINE = LINE_LEN'(NUM_LINES - 1);
    localparam logic [COL_LEN-1:0]  LAST_COL  = COL_LEN'(NUM_COLS - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_CHECK      = 4'd1,
        S_REQ        = 4'd2,
        S_REARB      = 4'd3,
        S_WAIT_DATA  = 4'd4,
        S_WAIT_CMPLT = 4'd5,
        S_PUSH       = 4'd6,
        S_ERR        = 4'd7,
        S_ADVANCE    = 4'd8,
        S_DONE       = 4'd9
    } state_t;

    state_t                    state_q, state_d;
    logic [LINE_LEN-1:0]       line_q, line_d;
    logic [COL_LEN-1:0]        col_q, col_d;
    logic [C_MST_DWIDTH-1:0]   pixel_q, pixel_d;
    logic                      err_q, err_d;
    logic [RAW_AW-1:0]         addr_raw;
    logic                      last_pixel;

    assign last_pixel = (line_q == LAST_LINE) && (col_q == LAST_COL);
    assign addr_raw   = {FB_BASE_HI, line_q, col_q, 2'b00};

    // State and datapath registers; reset abandons any bus transaction in flight.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            col_q   <= '0;
            pixel_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            col_q   <= col_d;
            pixel_q <= pixel_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: one single-beat read per pixel, one read outstanding at a time.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        col_d   = col_q;
        pixel_d = pixel_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CHECK;
                    line_d  = '0;
                    col_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_CHECK: begin
                // A FIFO slot must exist before the read goes out, so data is never stranded.
                if (!fifo_full) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A failed command outranks an acknowledge seen in the same cycle.
                if (Bus2IP_Mst_Error || Bus2IP_Mst_Cmd_Timeout) begin
                    state_d = S_ERR;
                end else if (Bus2IP_Mst_CmdAck) begin
                    state_d = S_WAIT_DATA;
                end else if (Bus2IP_Mst_Rearbitrate) begin
                    state_d = S_REARB;
                end
            end
            S_REARB: begin
                state_d = S_REQ;
            end
            S_WAIT_DATA: begin
                if (Bus2IP_Mst_Error) begin
                    state_d = S_ERR;
                end else if (!Bus2IP_MstRd_src_rdy_n) begin
                    pixel_d = Bus2IP_MstRd_d;
                    state_d = Bus2IP_Mst_Cmplt ? S_PUSH : S_WAIT_CMPLT;
                end
            end
            S_WAIT_CMPLT: begin
                if (Bus2IP_Mst_Error) begin
                    state_d = S_ERR;
                end else if (Bus2IP_Mst_Cmplt) begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                state_d = S_ADVANCE;
            end
            S_ERR: begin
                // The pixel is dropped; the scan resumes once the bus lowers Error.
                err_d = 1'b1;
                if (!Bus2IP_Mst_Error) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (last_pixel) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CHECK;
                    if (col_q == LAST_COL) begin
                        col_d  = '0;
                        line_d = line_q + 1'b1;
                    end else begin
                        col_d  = col_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy                   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign frame_done             = (state_q == S_DONE);
    assign err_sticky             = err_q;
    assign fifo_wr_en             = (state_q == S_PUSH);
    assign fifo_Dout              = {line_q, col_q, {PAD_W{1'b0}}, pixel_q};
    assign IP2Bus_MstRd_Req       = (state_q == S_REQ);
    assign IP2Bus_MstWr_Req       = 1'b0;
    assign IP2Bus_Mst_Addr        = C_MST_AWIDTH'(addr_raw);
    assign IP2Bus_Mst_BE          = '1;
    assign IP2Bus_Mst_Lock        = 1'b0;
    assign IP2Bus_Mst_Reset       = 1'b0;
    assign IP2Bus_MstRd_dst_rdy_n = (state_q != S_WAIT_DATA);

endmodule

// File: tb/tb_fb_scan_reader.sv
// tb/tb_fb_scan_reader.sv - randomized scoreboard bench for fb_scan_reader
module tb_fb_scan_reader;

    localparam int NL = 2;
    localparam int NC = 3;
    localparam logic [10:0] FB_HI = 11'b1001_0000_000;

    logic        clk;
    logic        Bus2IP_Resetn;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        err_sticky;
    logic [63:0] fifo_Dout;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        Req;
    logic        WrReq;
    logic [31:0] Addr;
    logic [3:0]  BE;
    logic        Lock;
    logic        MstReset;
    logic        dst_rdy_n;
    logic        CmdAck;
    logic        Cmplt;
    logic        Error;
    logic        Rearb;
    logic        Timeout;
    logic [31:0] rd_d;
    logic        src_rdy_n;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          nwrites = 0;
    bit          hung = 0;
    logic [63:0] sb[$];
    int          wr_cycles[$];
    logic [31:0] addr_log[$];

    fb_scan_reader #(.NUM_LINES(NL), .NUM_COLS(NC)) dut (
        .Bus2IP_Clk(clk),
        .Bus2IP_Resetn(Bus2IP_Resetn),
        .start(start),
        .busy(busy),
        .frame_done(frame_done),
        .err_sticky(err_sticky),
        .fifo_Dout(fifo_Dout),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full),
        .IP2Bus_MstRd_Req(Req),
        .IP2Bus_MstWr_Req(WrReq),
        .IP2Bus_Mst_Addr(Addr),
        .IP2Bus_Mst_BE(BE),
        .IP2Bus_Mst_Lock(Lock),
        .IP2Bus_Mst_Reset(MstReset),
        .IP2Bus_MstRd_dst_rdy_n(dst_rdy_n),
        .Bus2IP_Mst_CmdAck(CmdAck),
        .Bus2IP_Mst_Cmplt(Cmplt),
        .Bus2IP_Mst_Error(Error),
        .Bus2IP_Mst_Rearbitrate(Rearb),
        .Bus2IP_Mst_Cmd_Timeout(Timeout),
        .Bus2IP_MstRd_d(rd_d),
        .Bus2IP_MstRd_src_rdy_n(src_rdy_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected word.
    always @(posedge clk) begin
        #1;
        if (fifo_wr_en === 1'b1) begin
            nwrites++;
            wr_cycles.push_back(cyc);
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) check("fifo_word", fifo_Dout, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (Req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("req_seen", 64'(ok), 64'd1);
    endtask

    // Error burst; any data or Cmplt driven alongside it is withdrawn after the first edge.
    task automatic err_burst(input int hold);
        Error = 1'b1;
        tick();
        src_rdy_n = 1'b1;
        Cmplt = 1'b0;
        repeat (hold) tick();
        Error = 1'b0;
        tick();
    endtask

    task automatic run_frame(input int rearb_idx, input int err_idx, input int stall_idx,
                             input int abort_idx, input bit rnd, input bit probe_start);
        int exp_writes;
        bit exp_err;
        bit ok;
        exp_writes = 0;
        exp_err = 1'b0;
        nwrites = 0;
        wr_cycles.delete();
        addr_log.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_on_start", 64'(busy), 64'd1);
        check("err_clear_on_start", 64'(err_sticky), 64'd0);
        for (int idx = 0; idx < NL * NC; idx++) begin
            int line, col, stall_len, ack_dly, outcome, nbad;
            bit sep;
            logic [31:0] exp_addr, pix;
            logic [63:0] word;
            line = idx / NC;
            col = idx % NC;
            exp_addr = {FB_HI, 9'(line), 10'(col), 2'b00};
            stall_len = (idx == stall_idx) ? 20 :
                        (rnd && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
            if (stall_len > 0) begin
                fifo_full = 1'b1;
                nbad = 0;
                for (int s = 0; s < stall_len; s++) begin
                    if (probe_start && s == 5) start = 1'b1;
                    tick();
                    start = 1'b0;
                    if (Req) nbad++;
                end
                check("req_low_while_full", 64'(nbad), 64'd0);
                if (probe_start) check("busy_ignores_start", 64'(busy), 64'd1);
                fifo_full = 1'b0;
            end
            wait_req(ok);
            if (!ok) begin
                hung = 1'b1;
                return;
            end
            check("req_addr", 64'(Addr), 64'(exp_addr));
            addr_log.push_back(Addr);
            if (idx == rearb_idx || (rnd && $urandom_range(0, 4) == 0)) begin
                Rearb = 1'b1;
                tick();
                Rearb = 1'b0;
                check("req_low_in_rearb", 64'(Req), 64'd0);
                tick();
                check("req_reissued", 64'(Req), 64'd1);
                check("rearb_addr", 64'(Addr), 64'(exp_addr));
            end
            ack_dly = rnd ? int'($urandom_range(0, 3)) : 0;
            if (ack_dly > 0) begin
                nbad = 0;
                repeat (ack_dly) begin
                    tick();
                    if (!Req) nbad++;
                end
                check("req_held_until_ack", 64'(nbad), 64'd0);
            end
            outcome = rnd ? int'($urandom_range(0, 11)) : 11;
            if (idx == err_idx) outcome = 2;
            if (outcome == 0) begin
                err_burst(rnd ? int'($urandom_range(0, 2)) : 0);
                exp_err = 1'b1;
                continue;
            end
            if (outcome == 1) begin
                Timeout = 1'b1;
                tick();
                Timeout = 1'b0;
                tick();
                exp_err = 1'b1;
                continue;
            end
            CmdAck = 1'b1;
            tick();
            CmdAck = 1'b0;
            check("dst_rdy_in_wait", 64'(dst_rdy_n), 64'd0);
            if (idx == abort_idx) begin
                #2;
                Bus2IP_Resetn = 1'b0;
                #1;
                check("async_rst_busy", 64'(busy), 64'd0);
                check("async_rst_req", 64'(Req), 64'd0);
                check("async_rst_dst_rdy", 64'(dst_rdy_n), 64'd1);
                check("async_rst_dout", fifo_Dout, 64'd0);
                check("async_rst_wr_en", 64'(fifo_wr_en), 64'd0);
                tick();
                Bus2IP_Resetn = 1'b1;
                tick();
                check("busy_after_reset", 64'(busy), 64'd0);
                check("no_write_after_abort", 64'(sb.size()), 64'd0);
                return;
            end
            repeat (rnd ? int'($urandom_range(0, 2)) : 0) tick();
            if (outcome == 2) begin
                src_rdy_n = 1'b0;
                rd_d = $urandom;
                Cmplt = 1'b1;
                err_burst(rnd ? int'($urandom_range(0, 2)) : 0);
                exp_err = 1'b1;
                continue;
            end
            pix = rnd ? 32'($urandom) : 32'hA000_0000 + 32'(idx);
            sep = (outcome == 3) ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
            word = {9'(line), 10'(col), 13'd0, pix};
            if (outcome != 3) begin
                sb.push_back(word);
                exp_writes++;
            end
            src_rdy_n = 1'b0;
            rd_d = pix;
            Cmplt = !sep;
            tick();
            src_rdy_n = 1'b1;
            rd_d = $urandom;
            Cmplt = 1'b0;
            if (sep) begin
                check("dst_rdy_released", 64'(dst_rdy_n), 64'd1);
                repeat (rnd ? int'($urandom_range(0, 2)) : 0) tick();
                if (outcome == 3) begin
                    err_burst(0);
                    exp_err = 1'b1;
                end else begin
                    Cmplt = 1'b1;
                    tick();
                    Cmplt = 1'b0;
                end
            end
        end
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            tick();
            if (frame_done) ok = 1'b1;
        end
        check("frame_done_seen", 64'(ok), 64'd1);
        if (ok) begin
            check("busy_low_at_done", 64'(busy), 64'd0);
            tick();
            check("frame_done_one_cycle", 64'(frame_done), 64'd0);
            check("busy_low_after_done", 64'(busy), 64'd0);
        end
        check("err_sticky_end", 64'(err_sticky), 64'(exp_err));
        check("write_count", 64'(nwrites), 64'(exp_writes));
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int gap_bad;
        Bus2IP_Resetn = 1'b0;
        start = 1'b0;
        fifo_full = 1'b0;
        CmdAck = 1'b0;
        Cmplt = 1'b0;
        Error = 1'b0;
        Rearb = 1'b0;
        Timeout = 1'b0;
        rd_d = '0;
        src_rdy_n = 1'b1;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_err", 64'(err_sticky), 64'd0);
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_req", 64'(Req), 64'd0);
        check("rst_dst_rdy_n", 64'(dst_rdy_n), 64'd1);
        check("rst_dout", fifo_Dout, 64'd0);
        check("tie_offs", {59'd0, WrReq, Lock, MstReset, BE[1:0]}, 64'h3);
        Bus2IP_Resetn = 1'b1;
        tick();

        // Baseline frame: immediate ack, data and Cmplt together.
        run_frame(-1, -1, -1, -1, 1'b0, 1'b0);
        gap_bad = 0;
        for (int i = 1; i < wr_cycles.size(); i++)
            if (wr_cycles[i] - wr_cycles[i-1] != 5) gap_bad++;
        check("pixel_period_5", 64'(gap_bad), 64'd0);
        if (addr_log.size() >= 4) begin
            check("addr_l0_c2", 64'(addr_log[2]), 64'h9000_0008);
            check("addr_l1_c0", 64'(addr_log[3]), 64'h9000_1000);
        end

        if (!hung) run_frame(-1, -1, 2, -1, 1'b0, 1'b1);
        if (!hung) run_frame(0, -1, -1, -1, 1'b0, 1'b0);
        if (!hung) begin
            run_frame(-1, 1, -1, -1, 1'b0, 1'b0);
            check("err_frame_words", 64'(nwrites), 64'd5);
        end
        if (!hung) run_frame(-1, -1, -1, 1, 1'b0, 1'b0);
        if (!hung) run_frame(-1, -1, -1, -1, 1'b0, 1'b0);
        for (int f = 0; f < 25 && !hung; f++) run_frame(-1, -1, -1, -1, 1'b1, 1'b0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
